div_32_seq: RTL and testbench

Multi-cycle 32-bit sequential divider for the ALU. It runs alongside the single-cycle logic units (AND/OR/NOT) and feeds the 64-bit Z result register. The quotient drives the low half of Z and the remainder drives the high half. Operands come from the Ra/Rb operand paths, and a start/done handshake lets the control unit stall the datapath while a division is in progress.

---
 rtl/div_32_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_div_32_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_32_seq.sv
// -----------------------------------------------------------------------------
// div_32_seq
//
// Multi-cycle 32-bit restoring divider for the ALU. A division is requested
// with a start pulse while idle. It then runs for a fixed number of cycles:
// one accepting edge, 32 iteration edges, one sign-fix edge and one DONE
// cycle. The quotient drives the low half of the Z result register and the
// remainder drives the high half.
//
// Configuration macro:
//   DIV_SIGNED_EN  defined   -> two's-complement signed division. The
//                               quotient truncates toward zero and the
//                               remainder takes the sign of the dividend.
//                  undefined -> unsigned division. The FIX state still runs
//                               as a pass-through, so latency is identical.
//
// Ports:
//   clock        in   rising-edge clock
//   clear        in   synchronous active-low reset
//   start        in   division request, sampled only in IDLE
//   Ra           in   dividend, latched on the accepting edge
//   Rb           in   divisor, latched on the accepting edge
//   busy         out  high whenever the state is not IDLE
//   done         out  one-cycle pulse; Zlow/Zhigh are valid from this cycle
//   Zlow         out  quotient
//   Zhigh        out  remainder
//   div_by_zero  out  set with done when Rb was 0; held until the next start
// -----------------------------------------------------------------------------
module div_32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] Ra,
  input  logic [WIDTH-1:0] Rb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Zlow,
  output logic [WIDTH-1:0] Zhigh,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [4:0]  cnt_r, cnt_s;
  logic [31:0] rem_r, rem_s;
  logic [31:0] quo_r, quo_s;
  logic [31:0] div_r, div_s;
  logic [31:0] zlow_r, zlow_s;
  logic [31:0] zhigh_r, zhigh_s;
  logic        dbz_r, dbz_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        accept_s;

  // Operand magnitudes loaded on accept, and FIX-stage results.
  logic [31:0] dvd_mag_s;
  logic [31:0] dvs_mag_s;
  logic [31:0] fix_quo_s;
  logic [31:0] fix_rem_s;

  // One restoring-division step.
  logic [32:0] partial_s;
  logic [32:0] diff_s;
  logic        take_s;
  logic [31:0] rem_step_s;
  logic [31:0] quo_step_s;

`ifdef DIV_SIGNED_EN
  // Two's-complement negation modulo 2^32.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    neg32 = (~v) + 32'd1;
  endfunction

  // Magnitude of a signed value. abs(0x80000000) wraps to 0x80000000,
  // which the unsigned core reads as 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    abs32 = v[31] ? neg32(v) : v;
  endfunction

  logic sign_q_r;  // quotient must be negated (operand signs differ)
  logic sign_r_r;  // remainder must be negated (dividend negative)

  assign dvd_mag_s = abs32(Ra);
  assign dvs_mag_s = abs32(Rb);
  assign fix_quo_s = sign_q_r ? neg32(quo_r) : quo_r;
  assign fix_rem_s = sign_r_r ? neg32(rem_r) : rem_r;

  // Capture the operand sign bits on every accepted start.
  always_ff @(posedge clock) begin
    if (!clear) begin
      sign_q_r <= 1'b0;
      sign_r_r <= 1'b0;
    end else if (accept_s) begin
      sign_q_r <= Ra[31] ^ Rb[31];
      sign_r_r <= Ra[31];
    end else begin
      sign_q_r <= sign_q_r;
      sign_r_r <= sign_r_r;
    end
  end
`else
  assign dvd_mag_s = Ra;
  assign dvs_mag_s = Rb;
  assign fix_quo_s = quo_r;
  assign fix_rem_s = rem_r;
`endif

  // Shift {rem, quo} left by one and trial-subtract the divisor. Because the
  // running remainder is always below the divisor, the shifted value fits in
  // 33 bits and bit 32 of the difference is the borrow (negative result).
  always_comb begin
    partial_s  = {rem_r, quo_r[31]};
    diff_s     = partial_s - {1'b0, div_r};
    take_s     = ~diff_s[32];
    rem_step_s = take_s ? diff_s[31:0] : partial_s[31:0];
    quo_step_s = {quo_r[30:0], take_s};
  end

  // Next-state and next-datapath logic for the control FSM.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    rem_s    = rem_r;
    quo_s    = quo_r;
    div_s    = div_r;
    zlow_s   = zlow_r;
    zhigh_s  = zhigh_r;
    dbz_s    = dbz_r;
    accept_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          cnt_s    = 5'd0;
          rem_s    = 32'd0;
          quo_s    = dvd_mag_s;
          div_s    = dvs_mag_s;
          if (Rb == 32'd0) begin
            // Divide by zero skips the iterations; Zhigh returns the raw Ra.
            state_s = ST_DONE;
            zlow_s  = 32'hFFFF_FFFF;
            zhigh_s = Ra;
            dbz_s   = 1'b1;
          end else begin
            state_s = ST_CALC;
            dbz_s   = 1'b0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_CALC: begin
        rem_s = rem_step_s;
        quo_s = quo_step_s;
        if (cnt_r == 5'd31) begin
          state_s = ST_FIX;
        end else begin
          cnt_s = cnt_r + 5'd1;
        end
      end

      ST_FIX: begin
        zlow_s  = fix_quo_s;
        zhigh_s = fix_rem_s;
        state_s = ST_DONE;
      end

      ST_DONE: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // DONE always exits after one cycle, so "next is DONE" marks exactly the
    // edge that enters it; this keeps done and busy as registered outputs.
    busy_s = (state_s != ST_IDLE);
    done_s = (state_s == ST_DONE);
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath, result and status registers.
  always_ff @(posedge clock) begin
    if (!clear) begin
      cnt_r   <= 5'd0;
      rem_r   <= 32'd0;
      quo_r   <= 32'd0;
      div_r   <= 32'd0;
      zlow_r  <= 32'd0;
      zhigh_r <= 32'd0;
      dbz_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      cnt_r   <= cnt_s;
      rem_r   <= rem_s;
      quo_r   <= quo_s;
      div_r   <= div_s;
      zlow_r  <= zlow_s;
      zhigh_r <= zhigh_s;
      dbz_r   <= dbz_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign Zlow        = zlow_r;
  assign Zhigh       = zhigh_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_div_32_seq.sv
// -----------------------------------------------------------------------------
// tb_div_32_seq
//
// Directed self-checking bench for div_32_seq. Expected values are
// hand-computed. Where the result depends on DIV_SIGNED_EN, both the signed
// and the unsigned expectation are given.
// -----------------------------------------------------------------------------
module tb_div_32_seq;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] Ra;
  logic [31:0] Rb;
  logic        busy;
  logic        done;
  logic [31:0] Zlow;
  logic [31:0] Zhigh;
  logic        div_by_zero;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  div_32_seq #(.WIDTH(32)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .Ra          (Ra),
    .Rb          (Rb),
    .busy        (busy),
    .done        (done),
    .Zlow        (Zlow),
    .Zhigh       (Zhigh),
    .div_by_zero (div_by_zero)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Start a division and run until done is seen. This task does no checking.
  // done_edge is the edge number of the done pulse (-1 on timeout).
  // busy_held reports whether busy stayed high from edge 0 through done.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         output int done_edge, output bit busy_held);
    Ra        = a;
    Rb        = b;
    start     = 1'b1;
    done_edge = -1;
    tick();
    start     = 1'b0;
    busy_held = (busy === 1'b1);
    if (done === 1'b1) begin
      done_edge = 0;
    end else begin
      for (int e = 1; e <= 40; e++) begin
        tick();
        if (busy !== 1'b1) busy_held = 1'b0;
        if (done === 1'b1) begin
          done_edge = e;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    clear = 1'b0;
    start = 1'b0;
    Ra    = 32'd0;
    Rb    = 32'd0;
    tick();
    tick();
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (Zlow !== 32'd0) $display("FAIL reset_zlow got %h want 0", Zlow); else passed++;
    total++; if (Zhigh !== 32'd0) $display("FAIL reset_zhigh got %h want 0", Zhigh); else passed++;
    total++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz got %b want 0", div_by_zero); else passed++;
    clear = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int de;
    bit bh;
    run_div(32'd100, 32'd7, de, bh);
    total++; if (de !== 33) $display("FAIL basic_done_edge got %0d want 33", de); else passed++;
    total++; if (!bh) $display("FAIL basic_busy_held got 0 want 1"); else passed++;
    total++; if (Zlow !== 32'd14) $display("FAIL basic_zlow got %h want 0000000e", Zlow); else passed++;
    total++; if (Zhigh !== 32'd2) $display("FAIL basic_zhigh got %h want 00000002", Zhigh); else passed++;
    total++; if (div_by_zero !== 1'b0) $display("FAIL basic_dbz got %b want 0", div_by_zero); else passed++;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL basic_idle_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL basic_idle_done got %b want 0", done); else passed++;
    total++; if (Zlow !== 32'd14) $display("FAIL basic_hold_zlow got %h want 0000000e", Zlow); else passed++;
  endtask

  task automatic test_signed();
    int de;
    bit bh;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    // -100 / 7
`ifdef DIV_SIGNED_EN
    exp_q = 32'hFFFF_FFF2;
    exp_r = 32'hFFFF_FFFE;
`else
    exp_q = 32'h2492_4916;
    exp_r = 32'h0000_0002;
`endif
    run_div(32'hFFFF_FF9C, 32'd7, de, bh);
    total++; if (de !== 33) $display("FAIL neg_done_edge got %0d want 33", de); else passed++;
    total++; if (Zlow !== exp_q) $display("FAIL neg_zlow got %h want %h", Zlow, exp_q); else passed++;
    total++; if (Zhigh !== exp_r) $display("FAIL neg_zhigh got %h want %h", Zhigh, exp_r); else passed++;
    tick();
    // 0x80000000 / 0xFFFFFFFF
`ifdef DIV_SIGNED_EN
    exp_q = 32'h8000_0000;
    exp_r = 32'h0000_0000;
`else
    exp_q = 32'h0000_0000;
    exp_r = 32'h8000_0000;
`endif
    run_div(32'h8000_0000, 32'hFFFF_FFFF, de, bh);
    total++; if (de !== 33) $display("FAIL min_done_edge got %0d want 33", de); else passed++;
    total++; if (Zlow !== exp_q) $display("FAIL min_zlow got %h want %h", Zlow, exp_q); else passed++;
    total++; if (Zhigh !== exp_r) $display("FAIL min_zhigh got %h want %h", Zhigh, exp_r); else passed++;
    total++; if (div_by_zero !== 1'b0) $display("FAIL min_dbz got %b want 0", div_by_zero); else passed++;
    tick();
  endtask

  task automatic test_unsigned_max();
    int de;
    bit bh;
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    // 0xFFFFFFFF / 2
`ifdef DIV_SIGNED_EN
    exp_q = 32'h0000_0000;
    exp_r = 32'hFFFF_FFFF;
`else
    exp_q = 32'h7FFF_FFFF;
    exp_r = 32'h0000_0001;
`endif
    run_div(32'hFFFF_FFFF, 32'd2, de, bh);
    total++; if (de !== 33) $display("FAIL umax_done_edge got %0d want 33", de); else passed++;
    total++; if (Zlow !== exp_q) $display("FAIL umax_zlow got %h want %h", Zlow, exp_q); else passed++;
    total++; if (Zhigh !== exp_r) $display("FAIL umax_zhigh got %h want %h", Zhigh, exp_r); else passed++;
    tick();
  endtask

  task automatic test_div_by_zero();
    int de;
    bit bh;
    run_div(32'd5, 32'd0, de, bh);
    total++; if (de !== 0) $display("FAIL dbz_done_edge got %0d want 0", de); else passed++;
    total++; if (Zlow !== 32'hFFFF_FFFF) $display("FAIL dbz_zlow got %h want ffffffff", Zlow); else passed++;
    total++; if (Zhigh !== 32'd5) $display("FAIL dbz_zhigh got %h want 00000005", Zhigh); else passed++;
    total++; if (div_by_zero !== 1'b1) $display("FAIL dbz_flag got %b want 1", div_by_zero); else passed++;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL dbz_idle_busy got %b want 0", busy); else passed++;
    total++; if (div_by_zero !== 1'b1) $display("FAIL dbz_hold got %b want 1", div_by_zero); else passed++;
    // A valid start clears the flag on its accepting edge.
    Ra    = 32'd45;
    Rb    = 32'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (div_by_zero !== 1'b0) $display("FAIL dbz_clear got %b want 0", div_by_zero); else passed++;
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (done === 1'b1) break;
    end
    total++; if (Zlow !== 32'd7 || Zhigh !== 32'd3)
      $display("FAIL dbz_next_result got %h/%h want 00000007/00000003", Zlow, Zhigh);
    else passed++;
    tick();
  endtask

  task automatic test_abort();
    bit saw_done;
    saw_done = 1'b0;
    Ra    = 32'd1000;
    Rb    = 32'd3;
    start = 1'b1;
    tick();                       // edge 0
    start = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      if (e == 5) begin
        Ra    = 32'd50;
        Rb    = 32'd5;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done === 1'b1) saw_done = 1'b1;
    end
    start = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL abort_busy_before got %b want 1", busy); else passed++;
    clear = 1'b0;
    tick();                       // edge 10
    clear = 1'b1;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
    total++; if (Zlow !== 32'd0) $display("FAIL abort_zlow got %h want 0", Zlow); else passed++;
    total++; if (Zhigh !== 32'd0) $display("FAIL abort_zhigh got %h want 0", Zhigh); else passed++;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    total++; if (saw_done) $display("FAIL abort_no_done got activity want none"); else passed++;
  endtask

  task automatic test_back_to_back();
    int de;
    bit bh;
    run_div(32'd1000, 32'd3, de, bh);
    total++; if (Zlow !== 32'd333 || Zhigh !== 32'd1)
      $display("FAIL b2b_first got %h/%h want 0000014d/00000001", Zlow, Zhigh);
    else passed++;
    tick();
    run_div(32'd12345, 32'd100, de, bh);
    total++; if (de !== 33) $display("FAIL b2b_done_edge got %0d want 33", de); else passed++;
    total++; if (Zlow !== 32'd123 || Zhigh !== 32'd45)
      $display("FAIL b2b_second got %h/%h want 0000007b/0000002d", Zlow, Zhigh);
    else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_unsigned_max();
    test_div_by_zero();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
